// File: rtl/cic_pkg.sv
// Shared types, sizes and helpers for the CIC decimator.
package cic_pkg;

    localparam int STAGES_MAX = 4;
    localparam int DATA_W     = 32;

    typedef logic signed [DATA_W-1:0] acc_t;

    // Requested stage count -> usable stage count in 1..max_k.
    function automatic logic [7:0] clamp_k(input logic [7:0] req, input int max_k);
        if (req == 8'd0)
            return 8'd1;
        if (int'(req) > max_k)
            return 8'(max_k);
        return req;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb section: y = x - x[previous decimation event], with load and clear.
module cic_comb_stage #(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] dout
);
    import cic_pkg::*;

    logic signed [W-1:0] dly;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dly <= '0;
        else if (clr)
            dly <= '0;
        else if (en)
            dly <= din;
    end

    assign dout = din - dly;

endmodule

// File: rtl/cic_decimator.sv
// Run-time configurable CIC decimator: 1-bit PDM in, DATA_W-bit PCM out.
// Define CIC_UNIPOLAR_INPUT_EN to map din=0 to 0 instead of -1.
module cic_decimator #(
    parameter int STAGES_MAX = cic_pkg::STAGES_MAX,
    parameter int DATA_W     = cic_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              new_data,
    input  logic              din,
    input  logic [7:0]        comb_num,
    input  logic [15:0]       dec_num,
    output logic [DATA_W-1:0] out,
    output logic              out_rdy
);
    import cic_pkg::*;

    typedef logic signed [DATA_W-1:0] word_t;

    logic        cfg_loaded;
    logic [7:0]  k_q;
    logic [15:0] r_q;
    logic [15:0] cnt;

    // Until the first edge after reset the ports act as the live config.
    logic [7:0]  k_port;
    logic [7:0]  k_cur;
    logic [15:0] r_cur;
    assign k_port = clamp_k(comb_num, STAGES_MAX);
    assign k_cur  = cfg_loaded ? k_q : k_port;
    assign r_cur  = cfg_loaded ? r_q : dec_num;

    logic accept, cnt_last, dec_evt, k_chg;
    assign accept   = clk_en & new_data;
    assign cnt_last = (r_cur <= 16'd1) || (cnt >= r_cur - 16'd1);
    assign dec_evt  = accept & cnt_last;
    assign k_chg    = dec_evt && (k_port != k_cur);

    word_t x;
`ifdef CIC_UNIPOLAR_INPUT_EN
    assign x = din ? word_t'(1) : word_t'(0);
`else
    assign x = din ? word_t'(1) : '1;
`endif

    // Integrators: every stage updates from the previous-cycle values.
    word_t integ_q [STAGES_MAX];
    word_t integ_d [STAGES_MAX];

    always_comb begin
        integ_d[0] = integ_q[0] + x;
        for (int i = 1; i < STAGES_MAX; i++)
            integ_d[i] = integ_q[i] + integ_q[i-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES_MAX; i++)
                integ_q[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < STAGES_MAX; i++)
                integ_q[i] <= integ_d[i];
        end
    end

    word_t tap;
    always_comb begin
        tap = integ_d[0];
        for (int i = 1; i < STAGES_MAX; i++)
            if (k_cur == 8'(i + 1))
                tap = integ_d[i];
    end

    // Unused upper stages are cleared every event so they stay at zero;
    // a k change clears everything so old and new configs never mix.
    logic [STAGES_MAX-1:0] comb_en, comb_clr;
    always_comb begin
        comb_en  = '0;
        comb_clr = '0;
        for (int i = 0; i < STAGES_MAX; i++) begin
            comb_en[i]  = dec_evt && (8'(i) < k_cur) && !k_chg;
            comb_clr[i] = dec_evt && ((8'(i) >= k_cur) || k_chg);
        end
    end

    word_t comb_out [STAGES_MAX];

    for (genvar g = 0; g < STAGES_MAX; g++) begin : g_comb
        word_t c_in, c_out;
        if (g == 0) begin : g_first
            assign c_in = tap;
        end else begin : g_next
            assign c_in = g_comb[g-1].c_out;
        end
        cic_comb_stage #(.W(DATA_W)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en   (comb_en[g]),
            .clr  (comb_clr[g]),
            .din  (c_in),
            .dout (c_out)
        );
        assign comb_out[g] = c_out;
    end

    word_t comb_sel;
    always_comb begin
        comb_sel = comb_out[0];
        for (int i = 1; i < STAGES_MAX; i++)
            if (k_cur == 8'(i + 1))
                comb_sel = comb_out[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_loaded <= 1'b0;
            k_q        <= 8'd1;
            r_q        <= 16'd0;
            cnt        <= '0;
            out        <= '0;
            out_rdy    <= 1'b0;
        end else if (clk_en) begin
            out_rdy <= dec_evt;
            if (!cfg_loaded) begin
                cfg_loaded <= 1'b1;
                k_q        <= k_port;
                r_q        <= dec_num;
            end
            if (accept)
                cnt <= cnt_last ? '0 : cnt + 16'd1;
            if (dec_evt) begin
                out <= comb_sel;
                k_q <= k_port;
                r_q <= dec_num;
            end
        end else begin
            out_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: directed table, corner sequences, random run.
module tb_cic_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        new_data;
    logic        din;
    logic [7:0]  comb_num;
    logic [15:0] dec_num;
    logic [31:0] out;
    logic        out_rdy;

    int n_chk  = 0;
    int n_pass = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    cic_decimator dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .new_data (new_data),
        .din      (din),
        .comb_num (comb_num),
        .dec_num  (dec_num),
        .out      (out),
        .out_rdy  (out_rdy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: integrator bank plus k-th finite difference of the
    // decimated tap sequence (history since the last reset or k change).
    int ig [4];
    int yq [$];
    int cnt_m, mk, mr, m_out;
    bit loaded, m_rdy;

    function automatic int binom(input int n, input int r);
        int v = 1;
        for (int i = 0; i < r; i++) v = v * (n - i) / (i + 1);
        return v;
    endfunction

    function automatic int clampk(input int n);
        if (n == 0) return 1;
        if (n > 4) return 4;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ig[i] = 0;
        yq.delete();
        cnt_m = 0; loaded = 0; mk = 1; mr = 0; m_out = 0; m_rdy = 0;
    endtask

    task automatic model_edge();
        int kp, kc, rc, x, tap, acc, term;
        int old [4];
        bit evt;
        if (!clk_en) begin
            m_rdy = 0;
            return;
        end
        kp = clampk(int'(comb_num));
        kc = loaded ? mk : kp;
        rc = loaded ? mr : int'(dec_num);
        evt = 0;
        if (new_data) begin
`ifdef CIC_UNIPOLAR_INPUT_EN
            x = din ? 1 : 0;
`else
            x = din ? 1 : -1;
`endif
            old = ig;
            ig[0] = old[0] + x;
            for (int i = 1; i < 4; i++) ig[i] = old[i] + old[i-1];
            tap = ig[kc-1];
            cnt_m++;
            if (cnt_m >= rc) begin
                cnt_m = 0;
                evt = 1;
            end
            if (evt) begin
                yq.push_back(tap);
                acc = 0;
                for (int j = 0; j <= kc; j++) begin
                    if (j < yq.size()) begin
                        term = binom(kc, j) * yq[yq.size() - 1 - j];
                        acc = (j % 2 == 1) ? acc - term : acc + term;
                    end
                end
                m_out = acc;
                if (kp != kc) yq.delete();
                while (yq.size() > 5) void'(yq.pop_front());
            end
        end
        m_rdy = evt;
        if (!loaded) begin
            loaded = 1; mk = kp; mr = int'(dec_num);
        end
        if (evt) begin
            mk = kp; mr = int'(dec_num);
        end
    endtask

    // One clock: drive, advance the model, then compare just after the edge.
    task automatic step(input bit ce, input bit nd, input bit d);
        clk_en = ce; new_data = nd; din = d;
        model_edge();
        @(posedge clk);
        #1;
        check("out_rdy", {31'b0, out_rdy}, {31'b0, m_rdy});
        check("out", out, m_out);
        if (out_rdy) pulses++;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_out", out, 32'd0);
        check("rst_rdy", {31'b0, out_rdy}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  cn;
        logic [15:0] dn;
        int          mode;   // 0 zeros, 1 ones, 2 alternating starting at 1
        int          nsamp;
        int          exp_out;
        int          exp_pulses;
    } vec_t;

    vec_t tbl [7];
    int   neg_dc, alt1, alt2;
    logic [31:0] held;

    initial begin
`ifdef CIC_UNIPOLAR_INPUT_EN
        neg_dc = 0; alt1 = 1; alt2 = 8;
`else
        neg_dc = -81; alt1 = 0; alt2 = 0;
`endif
        tbl[0] = '{8'd4, 16'd3, 1, 30, 81,     10};
        tbl[1] = '{8'd4, 16'd3, 0, 30, neg_dc, 10};
        tbl[2] = '{8'd1, 16'd2, 2, 20, alt1,   10};
        tbl[3] = '{8'd2, 16'd4, 2, 40, alt2,   10};
        tbl[4] = '{8'd0, 16'd5, 1, 25, 5,      5};
        tbl[5] = '{8'd9, 16'd2, 1, 24, 16,     12};
        tbl[6] = '{8'd1, 16'd0, 1, 10, 1,      10};

        rst = 1'b0; clk_en = 1'b0; new_data = 1'b0; din = 1'b0;
        comb_num = 8'd4; dec_num = 16'd3;
        model_reset();
        #12;
        do_reset();

        for (int v = 0; v < 7; v++) begin
            do_reset();
            comb_num = tbl[v].cn;
            dec_num  = tbl[v].dn;
            pulses   = 0;
            for (int s = 0; s < tbl[v].nsamp; s++)
                step(1'b1, 1'b1, (tbl[v].mode == 2) ? (s % 2 == 0) : tbl[v].mode[0]);
            check($sformatf("vec%0d_final", v), out, tbl[v].exp_out);
            check($sformatf("vec%0d_pulses", v), pulses, tbl[v].exp_pulses);
        end

        // Asynchronous reset mid-stream, then no output before R strobes.
        do_reset();
        comb_num = 8'd4; dec_num = 16'd3;
        for (int s = 0; s < 12; s++) step(1'b1, 1'b1, 1'b1);
        do_reset();
        pulses = 0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("no_early_rdy", pulses, 0);
        step(1'b1, 1'b1, 1'b1);
        check("first_rdy", pulses, 1);

        // clk_en low: strobes ignored, outputs frozen.
        for (int s = 0; s < 4; s++) step(1'b1, 1'b1, 1'b1);
        held = out;
        for (int s = 0; s < 10; s++) step(1'b0, 1'b1, s[0]);
        check("hold_out", out, held);
        for (int s = 0; s < 20; s++) step(1'b1, 1'b1, 1'b1);

        // R changes 3 -> 8 mid-frame; current frame still ends after 3.
        do_reset();
        comb_num = 8'd4; dec_num = 16'd3;
        for (int s = 0; s < 4; s++) step(1'b1, 1'b1, 1'b1);
        dec_num = 16'd8;
        pulses = 0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("old_frame_end", pulses, 1);
        for (int s = 0; s < 72; s++) step(1'b1, 1'b1, 1'b1);
        check("r8_steady", out, 32'd4096);
        check("r8_pulses", pulses, 10);

        // k changes mid-frame.
        do_reset();
        comb_num = 8'd2; dec_num = 16'd4;
        for (int s = 0; s < 22; s++) step(1'b1, 1'b1, 1'b1);
        comb_num = 8'd3;
        for (int s = 0; s < 40; s++) step(1'b1, 1'b1, 1'b1);
        check("k3_steady", out, 32'd64);

        // Randomized traffic with live config changes and occasional resets.
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 99) < 3) begin
                comb_num = 8'($urandom_range(0, 9));
                dec_num  = 16'($urandom_range(0, 10));
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
